// File: rtl/vme_slave_ctrl.sv
// VME A16/D16 slave cycle controller: strobe synchronisers, base/AM decode, read/write sequencing, DTACK*.
// Optional ACK/RELEASE watchdog built only when VME_TIMEOUT_EN is defined.
module vme_slave_ctrl #(
  parameter logic [7:0] BASE_ADDR   = 8'h7C,
  parameter int         SYNC_STAGES = 2,
  parameter int         WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] VME_A,
  input  logic [5:0]  VME_AM,
  input  logic        VME_AS_N,
  input  logic [1:0]  VME_DS_N,
  input  logic        VME_WRITE_N,
  input  logic [15:0] VME_D_IN,
  output logic [15:0] VME_D_OUT,
  output logic        VME_D_OE,
  output logic        VME_DTACK_N,
  output logic [15:0] ADDR,
  input  logic [15:0] DIN,
  output logic        WR_STB,
  output logic [15:0] WR_DATA,
  output logic        BUSY,
  output logic        TIMEOUT
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_RD_WAIT   = 3'd2;
  localparam logic [2:0] S_RD_LATCH  = 3'd3;
  localparam logic [2:0] S_WR_STROBE = 3'd4;
  localparam logic [2:0] S_ACK       = 3'd5;
  localparam logic [2:0] S_RELEASE   = 3'd6;

  localparam logic [5:0] AM_A16_USER  = 6'h29;
  localparam logic [5:0] AM_A16_SUPER = 6'h2D;
  localparam logic [3:0] WAIT_LAST    = 4'(WAIT_CYCLES - 1);

  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic                        w_as_n;
  logic [1:0]                  w_ds_n;
  logic                        w_write_n;

  logic [2:0]  r_state;
  logic [2:0]  w_nxt;
  logic [3:0]  r_wait_cnt;
  logic [5:0]  r_am;
  logic        r_wr_n;
  logic        r_as_lock;
  logic        w_match;
  logic        w_tmo;
  logic        w_unused;

  logic        r_dtack_n;
  logic        r_oe;
  logic        r_wr_stb;
  logic        r_timeout;
  logic [15:0] r_addr;
  logic [15:0] r_dout;
  logic [15:0] r_wr_data;

  // Bit packing per stage: {WRITE_N, DS1*, DS0*, AS*}; preset to all-inactive.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {VME_WRITE_N, VME_DS_N, VME_AS_N}};
    end
  end

  assign w_as_n    = r_sync[SYNC_STAGES-1][0];
  assign w_ds_n    = r_sync[SYNC_STAGES-1][2:1];
  assign w_write_n = r_sync[SYNC_STAGES-1][3];
  assign w_unused  = VME_A[0];

  assign w_match = (r_addr[15:8] == BASE_ADDR) &&
                   ((r_am == AM_A16_USER) || (r_am == AM_A16_SUPER));

`ifdef VME_TIMEOUT_EN
  logic [7:0] r_wdog;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wdog <= 8'd0;
    end else if (w_nxt != r_state) begin
      r_wdog <= 8'd0;
    end else if ((r_state == S_ACK) || (r_state == S_RELEASE)) begin
      r_wdog <= r_wdog + 8'd1;
    end
  end

  assign w_tmo = ((r_state == S_ACK) || (r_state == S_RELEASE)) && (r_wdog == 8'hFF);
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_as_n && (w_ds_n == 2'b00) && !r_as_lock) w_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (w_as_n)                             w_nxt = S_IDLE;
        else if (!w_match || (w_ds_n != 2'b00)) w_nxt = S_RELEASE;
        else if (r_wr_n)                        w_nxt = S_RD_WAIT;
        else                                    w_nxt = S_WR_STROBE;
      end
      S_RD_WAIT: begin
        if (w_as_n)                        w_nxt = S_IDLE;
        else if (r_wait_cnt == WAIT_LAST)  w_nxt = S_RD_LATCH;
      end
      S_RD_LATCH: begin
        w_nxt = w_as_n ? S_IDLE : S_ACK;
      end
      S_WR_STROBE: begin
        w_nxt = w_as_n ? S_IDLE : S_ACK;
      end
      S_ACK: begin
        if (w_tmo)                  w_nxt = S_IDLE;
        else if (w_ds_n == 2'b11)   w_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (w_tmo || w_as_n) w_nxt = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_as_lock  <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_wait_cnt <= (r_state == S_RD_WAIT) ? r_wait_cnt + 4'd1 : 4'd0;
      // After a watchdog abort the master may still hold AS; wait for it to drop.
      if (w_tmo)       r_as_lock <= 1'b1;
      else if (w_as_n) r_as_lock <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_addr    <= 16'd0;
      r_am      <= 6'd0;
      r_wr_n    <= 1'b1;
      r_dout    <= 16'd0;
      r_wr_data <= 16'd0;
      r_oe      <= 1'b0;
      r_dtack_n <= 1'b1;
      r_wr_stb  <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_nxt == S_DECODE)) begin
        r_addr <= {VME_A[15:1], 1'b0};
        r_am   <= VME_AM;
        r_wr_n <= w_write_n;
      end
      if ((r_state == S_RD_WAIT) && (w_nxt == S_RD_LATCH)) r_dout <= DIN;
      if ((r_state == S_DECODE) && (w_nxt == S_WR_STROBE)) r_wr_data <= VME_D_IN;
      // OE leads DTACK by one clock on reads and drops together with it.
      r_oe      <= (w_nxt == S_RD_LATCH) || ((w_nxt == S_ACK) && r_oe);
      r_dtack_n <= (w_nxt != S_ACK);
      r_wr_stb  <= (w_nxt == S_WR_STROBE);
      r_timeout <= w_tmo;
    end
  end

  assign VME_D_OUT   = r_dout;
  assign VME_D_OE    = r_oe;
  assign VME_DTACK_N = r_dtack_n;
  assign ADDR        = r_addr;
  assign WR_STB      = r_wr_stb;
  assign WR_DATA     = r_wr_data;
  assign BUSY        = (r_state != S_IDLE);
  assign TIMEOUT     = r_timeout;

endmodule

// File: tb/tb_vme_slave_ctrl.sv
// Bench for vme_slave_ctrl: scoreboarded VME read/write cycles, decode misses, abort and mid-cycle reset.
module tb_vme_slave_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int WAIT_CYCLES = 2;
  localparam int RD_LAT      = SYNC_STAGES + 5;  // raw strobe edge -> DTACK low, in clocks
  localparam int WR_LAT      = SYNC_STAGES + 3;

  logic        CLK;
  logic        RST_N;
  logic [15:0] VME_A;
  logic [5:0]  VME_AM;
  logic        VME_AS_N;
  logic [1:0]  VME_DS_N;
  logic        VME_WRITE_N;
  logic [15:0] VME_D_IN;
  logic [15:0] VME_D_OUT;
  logic        VME_D_OE;
  logic        VME_DTACK_N;
  logic [15:0] ADDR;
  logic [15:0] DIN;
  logic        WR_STB;
  logic [15:0] WR_DATA;
  logic        BUSY;
  logic        TIMEOUT;

  vme_slave_ctrl #(
    .BASE_ADDR  (8'h7C),
    .SYNC_STAGES(SYNC_STAGES),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .VME_A      (VME_A),
    .VME_AM     (VME_AM),
    .VME_AS_N   (VME_AS_N),
    .VME_DS_N   (VME_DS_N),
    .VME_WRITE_N(VME_WRITE_N),
    .VME_D_IN   (VME_D_IN),
    .VME_D_OUT  (VME_D_OUT),
    .VME_D_OE   (VME_D_OE),
    .VME_DTACK_N(VME_DTACK_N),
    .ADDR       (ADDR),
    .DIN        (DIN),
    .WR_STB     (WR_STB),
    .WR_DATA    (WR_DATA),
    .BUSY       (BUSY),
    .TIMEOUT    (TIMEOUT)
  );

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk;
  int   n_err;
  int   n_ack;
  int   exp_n_ack;
  bit   tmo_seen;
  logic prev_stb;
  logic prev_dtack_n;
  logic prev_oe;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every write strobe and every read acknowledge.
  always @(negedge CLK) begin
    exp_t e;
    if (RST_N) begin
      if (TIMEOUT) tmo_seen = 1'b1;
      if (WR_STB) begin
        check("stb_one_clk", prev_stb, 1'b0);
        if (sb_q.size() == 0) begin
          check("wr_unexpected", WR_STB, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("wr_kind", e.is_wr, 1'b1);
          check("wr_addr", ADDR, e.addr);
          check("wr_data", WR_DATA, e.data);
        end
      end
      if (prev_dtack_n && !VME_DTACK_N) begin
        n_ack++;
        if (!prev_stb) begin
          if (sb_q.size() == 0) begin
            check("ack_unexpected", VME_DTACK_N, 1'b1);
          end else begin
            e = sb_q.pop_front();
            check("rd_kind", e.is_wr, 1'b0);
            check("rd_oe_setup", prev_oe, 1'b1);
            check("rd_oe", VME_D_OE, 1'b1);
            check("rd_addr", ADDR, e.addr);
            check("rd_dout", VME_D_OUT, e.data);
          end
        end
      end
    end
    prev_stb     = WR_STB;
    prev_dtack_n = VME_DTACK_N;
    prev_oe      = VME_D_OE;
  end

  task automatic drive_idle();
    VME_AS_N    = 1'b1;
    VME_DS_N    = 2'b11;
    VME_WRITE_N = 1'b1;
  endtask

  task automatic start_cycle(input logic [15:0] a, input logic [5:0] am, input logic wr,
                             input logic [15:0] dat, input bit exp_ack);
    exp_t e;
    @(negedge CLK);
    if (exp_ack) begin
      e.is_wr = wr;
      e.addr  = {a[15:1], 1'b0};
      e.data  = dat;
      sb_q.push_back(e);
      exp_n_ack++;
    end
    VME_A       = a;
    VME_AM      = am;
    VME_WRITE_N = !wr;
    VME_D_IN    = wr ? dat : 16'h0000;
    DIN         = wr ? 16'h0000 : dat;
    VME_AS_N    = 1'b0;
    VME_DS_N    = 2'b00;
  endtask

  task automatic wait_dtack(output int n, output bit got);
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(negedge CLK);
      n++;
      if (!VME_DTACK_N) got = 1'b1;
    end
  endtask

  task automatic vme_cycle(input logic [15:0] a, input logic [5:0] am, input logic wr,
                           input logic [15:0] dat, input bit exp_ack);
    int n;
    bit got;
    start_cycle(a, am, wr, dat, exp_ack);
    wait_dtack(n, got);
    check("addr_out", ADDR, {a[15:1], 1'b0});
    if (exp_ack) begin
      check(wr ? "wr_latency" : "rd_latency", n, wr ? WR_LAT : RD_LAT);
    end else begin
      check("no_dtack", got, 1'b0);
      check("release_busy", BUSY, 1'b1);
    end
    VME_DS_N = 2'b11;
    repeat (SYNC_STAGES + 1) @(negedge CLK);
    if (exp_ack) begin
      check("ds_rel_dtack", VME_DTACK_N, 1'b1);
      check("ds_rel_oe", VME_D_OE, 1'b0);
    end
    VME_AS_N = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge CLK);
    check("back_idle", BUSY, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    bit          got;
    bit          busy_seen;
    logic [15:0] d;
    logic [15:0] a;

    n_chk = 0; n_err = 0; n_ack = 0; exp_n_ack = 0; tmo_seen = 1'b0;
    prev_stb = 1'b0; prev_dtack_n = 1'b1; prev_oe = 1'b0;
    VME_A = 16'h0; VME_AM = 6'h0; VME_D_IN = 16'h0; DIN = 16'h0;
    drive_idle();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_dtack_n", VME_DTACK_N, 1'b1);
    check("rst_oe", VME_D_OE, 1'b0);
    check("rst_dout", VME_D_OUT, 16'h0);
    check("rst_addr", ADDR, 16'h0);
    check("rst_wr_stb", WR_STB, 1'b0);
    check("rst_wr_data", WR_DATA, 16'h0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_timeout", TIMEOUT, 1'b0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    vme_cycle(16'h7C84, 6'h29, 1'b0, 16'hA5A5, 1'b1);
    vme_cycle(16'h7CA2, 6'h29, 1'b1, 16'h1234, 1'b1);
    vme_cycle(16'h7D80, 6'h29, 1'b0, 16'hBEEF, 1'b0);
    vme_cycle(16'h7C84, 6'h39, 1'b0, 16'hBEEF, 1'b0);
    vme_cycle(16'h7D10, 6'h2D, 1'b1, 16'hDEAD, 1'b0);
    vme_cycle(16'h7C85, 6'h2D, 1'b0, 16'h0F0F, 1'b1);

    // AS held low for one clock only: the synchronised AS is already high in DECODE.
    @(negedge CLK);
    VME_A = 16'h7C90; VME_AM = 6'h29; VME_WRITE_N = 1'b0; VME_D_IN = 16'h5555;
    VME_AS_N = 1'b0; VME_DS_N = 2'b00;
    @(negedge CLK);
    VME_AS_N  = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1; i++) begin
      @(negedge CLK);
      if (BUSY) busy_seen = 1'b1;
    end
    check("abort_decode_seen", busy_seen, 1'b1);
    check("abort_busy", BUSY, 1'b0);
    check("abort_dtack", VME_DTACK_N, 1'b1);
    repeat (4) @(negedge CLK);
    check("abort_idle", BUSY, 1'b0);
    VME_DS_N = 2'b11; VME_WRITE_N = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge CLK);

    for (int k = 0; k < 6; k++) begin
      d = 16'($urandom);
      a = {8'h7C, 1'b1, 7'($urandom_range(0, 127))};
      vme_cycle(a, (k % 3 == 0) ? 6'h2D : 6'h29, k[0], d, 1'b1);
    end

    // Reset asserted while the read is in ACK must drop DTACK/OE without a clock edge.
    start_cycle(16'h7C88, 6'h29, 1'b0, 16'h5A5A, 1'b1);
    wait_dtack(n, got);
    check("rst_rd_latency", n, RD_LAT);
    #2 RST_N = 1'b0;
    #1;
    check("async_rst_dtack", VME_DTACK_N, 1'b1);
    check("async_rst_oe", VME_D_OE, 1'b0);
    check("async_rst_busy", BUSY, 1'b0);
    drive_idle();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    vme_cycle(16'h7C80, 6'h29, 1'b0, 16'hC3C3, 1'b1);

    repeat (4) @(negedge CLK);
    check("sb_empty", sb_q.size(), 0);
    check("ack_count", n_ack, exp_n_ack);
    check("no_timeout", tmo_seen, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
